logic_gate_unit: RTL and testbench

LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

---
 rtl/logic_gate_pkg.sv | 19 +
 rtl/gate_alu.sv | 30 +++
 rtl/logic_gate_unit.sv | 98 +++++++++
 tb/tb_logic_gate_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic gate unit: op encodings and op width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package logic_gate_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,  // NOT a, b ignored
    OP_BUF  = 3'd7   // pass a, b ignored
  } op_e;

endpackage

// File: rtl/gate_alu.sv
// Bitwise gate evaluation of a and b selected by op.
// Latency: purely combinational (0 cycles).
// Backpressure: none, no handshake on this block.
// Ports: a, b (WIDTH operands), op (OP_W select), y (WIDTH result).
module gate_alu
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op_e'(op))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      OP_BUF:  y = a;
    endcase
  end

endmodule

// File: rtl/logic_gate_unit.sv
// Two-stage valid/ready pipeline applying a bitwise gate op to a and b.
// Latency: 2 cycles input transfer to out_valid; one result per cycle sustained.
// Backpressure: out_ready=0 stalls S2, then S1; in_ready drops once both are full.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with a, b, op;
//        out_valid/out_ready with y, y_op; count = saturating output transfer count.
module logic_gate_unit
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [OP_W-1:0]  y_op,
  output logic [CNT_W-1:0] count
);

  // Stage 1: captured operands
  logic             s1_vld;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [OP_W-1:0]  s1_op;

  // Stage 2: registered result
  logic             s2_vld;
  logic [WIDTH-1:0] s2_y;
  logic [OP_W-1:0]  s2_op;

  logic [WIDTH-1:0] alu_y;
  logic             out_xfer;
  logic             s2_load;
  logic             s1_load;

  assign out_xfer = s2_vld & out_ready;
  assign s2_load  = ~s2_vld | out_xfer;
  // S1 can refill in the same cycle S2 drains it, giving full throughput.
  assign s1_load  = ~s1_vld | s2_load;
  assign in_ready = s1_load;

  gate_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (s1_a),
    .b  (s1_b),
    .op (s1_op),
    .y  (alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_op  <= '0;
    end else if (s1_load) begin
      // Advancing with no new input leaves a bubble.
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_a  <= a;
        s1_b  <= b;
        s1_op <= op;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld <= 1'b0;
      s2_y   <= '0;
      s2_op  <= '0;
    end else if (s2_load) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_y  <= alu_y;
        s2_op <= s1_op;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (out_xfer && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

  assign out_valid = s2_vld;
  assign y         = s2_y;
  assign y_op      = s2_op;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench: four instances (8b/16b count, 8b/2b count, 1b, 64b) share
// handshakes; a queue scoreboard predicts out_valid, in_ready, y, y_op and count.
// Each instance sees the same operands replicated/truncated to its width.
module tb_logic_gate_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  a, b;
  logic [2:0]  op;
  logic [0:0]  a1, b1;
  logic [63:0] a64, b64;

  logic        in_ready, out_valid;
  logic [7:0]  y;
  logic [2:0]  y_op;
  logic [15:0] count;

  logic        rdy_c2, ov_c2;
  logic [7:0]  y_c2;
  logic [2:0]  yop_c2;
  logic [1:0]  count_c2;

  logic        rdy_w1, ov_w1;
  logic [0:0]  y_w1;
  logic [2:0]  yop_w1;
  logic [15:0] count_w1;

  logic        rdy_w64, ov_w64;
  logic [63:0] y_w64;
  logic [2:0]  yop_w64;
  logic [15:0] count_w64;

  logic_gate_unit #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .y_op(y_op), .count(count));

  logic_gate_unit #(.WIDTH(8), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c2), .a(a), .b(b), .op(op),
    .out_valid(ov_c2), .out_ready(out_ready), .y(y_c2), .y_op(yop_c2), .count(count_c2));

  logic_gate_unit #(.WIDTH(1), .CNT_W(16)) dut_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w1), .a(a1), .b(b1), .op(op),
    .out_valid(ov_w1), .out_ready(out_ready), .y(y_w1), .y_op(yop_w1), .count(count_w1));

  logic_gate_unit #(.WIDTH(64), .CNT_W(16)) dut_w64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w64), .a(a64), .b(b64), .op(op),
    .out_valid(ov_w64), .out_ready(out_ready), .y(y_w64), .y_op(yop_w64), .count(count_w64));

  typedef struct {
    logic [7:0] ey;
    logic [2:0] eop;
    int         t;   // first cycle the result may be visible
  } ent_t;

  ent_t q[$];
  int   cyc   = 0;
  int   cnt   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [7:0] gate_ref(input logic [7:0] x, input logic [7:0] z, input logic [2:0] o);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return ~(x & z);
      3'd3: return ~(x | z);
      3'd4: return x ^ z;
      3'd5: return ~(x ^ z);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [2:0] iop, input logic ordy);
    in_valid  = v;
    a         = ia;
    b         = ib;
    op        = iop;
    a1        = ia[0:0];
    b1        = ib[0:0];
    a64       = {8{ia}};
    b64       = {8{ib}};
    out_ready = ordy;
  endtask

  // One clock cycle: drive, check against the scoreboard, advance the model.
  task automatic cycle(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [2:0] iop, input logic ordy, input logic [7:0] ey);
    logic exp_ov, exp_ir, in_x, out_x;
    int   cap;
    set_in(v, ia, ib, iop, ordy);
    #1;
    exp_ov = (q.size() > 0) && (q[0].t <= cyc);
    exp_ir = !((q.size() == 2) && !ordy);
    chk("in_ready", 64'(in_ready), 64'(exp_ir));
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    chk("in_ready_c2", 64'(rdy_c2), 64'(exp_ir));
    chk("out_valid_c2", 64'(ov_c2), 64'(exp_ov));
    chk("in_ready_w1", 64'(rdy_w1), 64'(exp_ir));
    chk("out_valid_w1", 64'(ov_w1), 64'(exp_ov));
    chk("in_ready_w64", 64'(rdy_w64), 64'(exp_ir));
    chk("out_valid_w64", 64'(ov_w64), 64'(exp_ov));
    if (exp_ov) begin
      chk("y", 64'(y), 64'(q[0].ey));
      chk("y_op", 64'(y_op), 64'(q[0].eop));
      chk("y_w1", 64'(y_w1), 64'(q[0].ey[0]));
      chk("y_w64", y_w64, {8{q[0].ey}});
      chk("y_op_w64", 64'(yop_w64), 64'(q[0].eop));
    end
    cap = (cnt > 3) ? 3 : cnt;
    chk("count", 64'(count), 64'(cnt));
    chk("count_c2", 64'(count_c2), 64'(cap));
    in_x  = v && exp_ir;
    out_x = exp_ov && ordy;
    @(posedge clk);
    cyc++;
    if (out_x) begin
      void'(q.pop_front());
      if (cnt < 65535) cnt++;
    end
    if (in_x) q.push_back('{ey: ey, eop: iop, t: cyc + 1});
    @(negedge clk);
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      cyc++;
    end
    q.delete();
    cnt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 8'h00);
  endtask

  logic [7:0] tab [8];
  logic [7:0] ra, rb;
  logic [2:0] rop;
  logic       rv, rr;

  initial begin
    tab[0] = 8'hC0; tab[1] = 8'hFC; tab[2] = 8'h3F; tab[3] = 8'h03;
    tab[4] = 8'h3C; tab[5] = 8'hC3; tab[6] = 8'h0F; tab[7] = 8'hF0;
    set_in(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    @(negedge clk);

    // Reset state
    do_reset(2);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_y_op", 64'(y_op), 64'd0);
    chk("rst_count", 64'(count), 64'd0);

    // All eight ops on F0/CC back to back, full throughput
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'hF0, 8'hCC, 3'(i), 1'b1, tab[i]);
    idle(3);

    // All-ones NAND and equal-operand XNOR across every width
    cycle(1'b1, 8'hFF, 8'hFF, 3'd2, 1'b1, 8'h00);
    cycle(1'b1, 8'h5A, 8'h5A, 3'd5, 1'b1, 8'hFF);
    cycle(1'b1, 8'hA5, 8'hA5, 3'd5, 1'b1, 8'hFF);
    idle(3);

    // Backpressure: two fill both stages, third waits for five stalled cycles
    cycle(1'b1, 8'h12, 8'h34, 3'd4, 1'b0, gate_ref(8'h12, 8'h34, 3'd4));
    cycle(1'b1, 8'h56, 8'h78, 3'd1, 1'b0, gate_ref(8'h56, 8'h78, 3'd1));
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 8'h9A, 8'hBC, 3'd3, 1'b0, gate_ref(8'h9A, 8'hBC, 3'd3));
    cycle(1'b1, 8'h9A, 8'hBC, 3'd3, 1'b1, gate_ref(8'h9A, 8'hBC, 3'd3));
    idle(4);

    // Reset with both stages full: nothing stale may appear afterwards
    cycle(1'b1, 8'h11, 8'h22, 3'd0, 1'b0, gate_ref(8'h11, 8'h22, 3'd0));
    cycle(1'b1, 8'h33, 8'h44, 3'd6, 1'b0, gate_ref(8'h33, 8'h44, 3'd6));
    cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00);
    set_in(1'b1, 8'h77, 8'h88, 3'd1, 1'b1);
    do_reset(1);
    idle(4);

    // Saturation of the 2-bit counter: count_c2 checked every cycle
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i), 8'hC3, 3'd4, 1'b1, gate_ref(8'(i), 8'hC3, 3'd4));
    idle(3);

    // Pseudo-random handshakes against the scoreboard
    for (int i = 0; i < 1000; i++) begin
      rv  = 1'($urandom_range(0, 1));
      rr  = 1'($urandom_range(0, 1));
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rop = 3'($urandom_range(0, 7));
      cycle(rv, ra, rb, rop, rr, gate_ref(ra, rb, rop));
    end
    idle(4);
    chk("final_count", 64'(count), 64'(cnt));
    chk("final_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
